branch_resolve: RTL

//  Downstream partner of the BTB. Carries each fetch-time prediction (PC, predicted taken, predicted target)

---
 rtl/branch_resolve.sv | 98 +++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Carries fetch-time BTB predictions through F/D and D/E and resolves them in Execute.
// Drives the BTB write port, the front-end redirect and the squash, and keeps saturating branch/mispredict counters.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCF,
  input  logic             BranchF,
  input  logic             PredictionF,
  input  logic [31:0]      PredictedTargetF,
  input  logic             StallD,
  input  logic             BranchE,
  input  logic             BranchTakenE,
  input  logic [31:0]      BranchTargetE,
  output logic             UpdateEnable,
  output logic             BranchTaken,
  output logic [31:0]      PCBranch,
  output logic [31:0]      PCUpdate,
  output logic             MispredictE,
  output logic [31:0]      RedirectPC,
  output logic             FlushFD,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pbr;
    logic        ptk;
    logic [31:0] ptgt;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_t fd_q;
  stage_t de_q;
  stage_t fd_in;
  logic   pred_tk;
  logic   br;
  logic   ghost;
  logic   mispredict;
  logic   update;

  // Prediction fields are only meaningful for predecoded branches; non-branches carry zeros.
  always_comb begin
    fd_in       = '0;
    fd_in.valid = 1'b1;
    fd_in.pc    = PCF;
    fd_in.pbr   = BranchF;
    fd_in.ptk   = BranchF & PredictionF;
    fd_in.ptgt  = BranchF ? PredictedTargetF : 32'd0;
  end

  assign pred_tk    = de_q.pbr & de_q.ptk;
  assign br         = de_q.valid & BranchE;
  assign ghost      = de_q.valid & ~BranchE & pred_tk;
  assign mispredict = ghost
                    | (br & ((pred_tk != BranchTakenE)
                           | (BranchTakenE & (de_q.ptgt != BranchTargetE))));
  assign update     = br | ghost;

  assign MispredictE  = mispredict;
  assign FlushFD      = mispredict;
  assign RedirectPC   = !mispredict               ? 32'd0 :
                        (br & BranchTakenE)       ? BranchTargetE :
                                                    de_q.pc + 32'd4;
  assign UpdateEnable = update;
  assign BranchTaken  = br & BranchTakenE;
  assign PCBranch     = br ? BranchTargetE : 32'd0;
  assign PCUpdate     = update ? de_q.pc : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fd_q            <= '0;
      de_q            <= '0;
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else begin
      // Redirect wins over a stall: both younger slots are wrong-path work.
      if (mispredict) begin
        fd_q.valid <= 1'b0;
        de_q.valid <= 1'b0;
      end else if (StallD) begin
        de_q.valid <= 1'b0;
      end else begin
        fd_q <= fd_in;
        de_q <= fd_q;
      end
      if (br && BranchCount != CNT_MAX)
        BranchCount <= BranchCount + CNT_W'(1);
      if (mispredict && MispredictCount != CNT_MAX)
        MispredictCount <= MispredictCount + CNT_W'(1);
    end
  end

endmodule
